dither_stream_sequencer: RTL and testbench

// - Frames an upstream pixel-group stream (valid/ready) into the in/in_valid/hsync/vsync timing required by the error diffusion datapath.
// - Guarantees gap-free in_valid within a line, because the datapath's x position advances every cycle of an active line.
// - Inserts drain blanking between lines so the 3-stage error write-back completes before hsync.
// - Sits between the frame fetch stream and the dithering datapath in the pixel pipeline.

---
 rtl/dither_stream_sequencer_pkg.sv | 24 ++
 rtl/dither_seq_counter.sv | 30 +++
 rtl/dither_stream_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_dither_stream_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dither_stream_sequencer_pkg.sv
// Shared definitions for the dither stream sequencer: FSM encoding, minimum
// horizontal blanking and statistics counter width.
// Imported by the top level and by the line/frame counter.
package dither_stream_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SOF = 3'd1,
    ST_VSYNC    = 3'd2,
    ST_LINE     = 3'd3,
    ST_HBLANK   = 3'd4
  } seq_state_t;

  // 3 cycles for the datapath error write-back to drain, plus 1 for hsync.
  localparam int MIN_HBLANK = 4;

  localparam int STAT_W = 16;

  // Width of a counter that must hold values 0..cycles.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/dither_seq_counter.sv
// Loadable down-counter with a terminal flag raised while the count is 1.
// A load takes priority over a decrement; the flag is decoded from the register.
// Used once for groups-per-line and once for lines-per-frame.
module dither_seq_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] cnt;

  // Remaining-items register: reload at the start of a run, count down per item.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/dither_stream_sequencer.sv
// Frames a valid/ready pixel-group stream into gap-free lines with vsync, drain
// blanking and hsync for the error diffusion datapath. All dith_* outputs are
// registered (1 cycle). Optional stats counters under `DITHER_SEQ_STATS_EN.
module dither_stream_sequencer
  import dither_stream_sequencer_pkg::*;
#(
  parameter int                    INPUT_BITS    = 8,
  parameter int                    PIXEL_RATE    = 4,
  parameter int                    HACT_BITS     = 10,
  parameter int                    VACT_BITS     = 11,
  parameter int                    HBLANK_CYCLES = 4,
  parameter logic [INPUT_BITS-1:0] PAD_VALUE     = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [HACT_BITS-1:0]             cfg_hact,
  input  logic [VACT_BITS-1:0]             cfg_vact,
  input  logic                             enable,
  input  logic [INPUT_BITS*PIXEL_RATE-1:0] s_data,
  input  logic                             s_sof,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic [INPUT_BITS*PIXEL_RATE-1:0] dith_in,
  output logic                             dith_in_valid,
  output logic                             dith_hsync,
  output logic                             dith_vsync,
  output logic                             busy,
  output logic                             underrun,
  output logic [STAT_W-1:0]                frame_cnt,
  output logic [STAT_W-1:0]                underrun_cnt
);

  // Blanking shorter than the drain depth would corrupt the error write-back.
  localparam int HBC  = (HBLANK_CYCLES < MIN_HBLANK) ? MIN_HBLANK : HBLANK_CYCLES;
  localparam int HB_W = cnt_width(HBC);

  seq_state_t           state_q, state_d;
  logic [HACT_BITS-1:0] hact_eff, hact_lat;
  logic [VACT_BITS-1:0] vact_eff;
  logic [HB_W-1:0]      hb_cnt;
  logic                 first_grp;
  logic                 resync_q;
  logic                 x_last, y_last, hb_last;
  logic                 sof_bad, pad;
  logic                 st_vsync, st_line;

  // A zero size would never reach the terminal count, so it is run as 1.
  assign hact_eff = (cfg_hact == '0) ? HACT_BITS'(1) : cfg_hact;
  assign vact_eff = (cfg_vact == '0) ? VACT_BITS'(1) : cfg_vact;

  assign st_vsync = (state_q == ST_VSYNC);
  assign st_line  = (state_q == ST_LINE);
  assign hb_last  = (state_q == ST_HBLANK) && (hb_cnt == HB_W'(HBC - 1));
  assign busy     = (state_q != ST_IDLE);

  dither_seq_counter #(.W(HACT_BITS)) u_x_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (st_vsync || (st_line && x_last)),
    .load_val (st_vsync ? hact_eff : hact_lat),
    .dec      (st_line),
    .last     (x_last)
  );

  dither_seq_counter #(.W(VACT_BITS)) u_y_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (st_vsync),
    .load_val (vact_eff),
    .dec      (hb_last),
    .last     (y_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: enable is only honoured at frame boundaries; resync forces a new vsync.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (!enable)                 state_d = ST_IDLE;
        else if (s_valid && s_sof)   state_d = ST_VSYNC;
      end
      ST_VSYNC: begin
        state_d = ST_LINE;
      end
      ST_LINE: begin
        if (x_last) state_d = ST_HBLANK;
      end
      ST_HBLANK: begin
        if (hb_last) begin
          if (resync_q)     state_d = ST_VSYNC;
          else if (!y_last) state_d = ST_LINE;
          else if (enable)  state_d = ST_WAIT_SOF;
          else              state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Upstream handshake and pad decision. The only input term in s_ready is the
  // sof reject, so an out-of-place sof group stays on the bus for the next frame.
  always_comb begin
    s_ready = 1'b0;
    sof_bad = 1'b0;
    pad     = 1'b0;
    unique case (state_q)
      ST_WAIT_SOF: begin
        s_ready = !(s_valid && s_sof);
      end
      ST_LINE: begin
        sof_bad = s_valid && s_sof && !first_grp;
        pad     = !s_valid || sof_bad || resync_q;
        s_ready = !sof_bad && !resync_q;
      end
      default: begin
        s_ready = 1'b0;
      end
    endcase
  end

  // Frame/line bookkeeping: latched line length, first-group marker, resync flag, blank timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      hact_lat  <= '0;
      first_grp <= 1'b0;
      resync_q  <= 1'b0;
      hb_cnt    <= '0;
    end else begin
      if (st_vsync) begin
        hact_lat  <= hact_eff;
        first_grp <= 1'b1;
        resync_q  <= 1'b0;
      end else if (st_line) begin
        first_grp <= 1'b0;
        if (sof_bad) resync_q <= 1'b1;
      end
      hb_cnt <= (state_q == ST_HBLANK) ? hb_cnt + HB_W'(1) : '0;
    end
  end

  // Registered datapath-facing outputs and the sticky underrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      dith_in       <= '0;
      dith_in_valid <= 1'b0;
      dith_hsync    <= 1'b0;
      dith_vsync    <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      dith_in_valid <= st_line;
      dith_in       <= !st_line ? '0 : (pad ? {PIXEL_RATE{PAD_VALUE}} : s_data);
      dith_hsync    <= hb_last;
      dith_vsync    <= st_vsync;
      if (st_vsync)  underrun <= 1'b0;
      else if (pad)  underrun <= 1'b1;
    end
  end

`ifdef DITHER_SEQ_STATS_EN
  logic [STAT_W-1:0] frame_q, urun_q;
  logic              frame_done;

  // A frame abandoned by resync is not counted as completed.
  assign frame_done = hb_last && y_last && !resync_q;

  // Free-running statistics, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
      urun_q  <= '0;
    end else begin
      if (frame_done) frame_q <= frame_q + STAT_W'(1);
      if (pad)        urun_q  <= urun_q + STAT_W'(1);
    end
  end

  assign frame_cnt    = frame_q;
  assign underrun_cnt = urun_q;
`else
  assign frame_cnt    = '0;
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_dither_stream_sequencer.sv
// Directed bench for dither_stream_sequencer: a cycle table for two frames
// (clean, then underrun) plus hand sequences for discard, resync, enable drop,
// zero config and reset.
module tb_dither_stream_sequencer;

`ifdef DITHER_SEQ_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  cfg_hact = 10'd4;
  logic [10:0] cfg_vact = 11'd2;
  logic        enable = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_sof = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] dith_in;
  logic        dith_in_valid, dith_hsync, dith_vsync, busy, underrun;
  logic [15:0] frame_cnt, underrun_cnt;

  int checks = 0;
  int failures = 0;

  dither_stream_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_hact      (cfg_hact),
    .cfg_vact      (cfg_vact),
    .enable        (enable),
    .s_data        (s_data),
    .s_sof         (s_sof),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .dith_in       (dith_in),
    .dith_in_valid (dith_in_valid),
    .dith_hsync    (dith_hsync),
    .dith_vsync    (dith_vsync),
    .busy          (busy),
    .underrun      (underrun),
    .frame_cnt     (frame_cnt),
    .underrun_cnt  (underrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        en, vld, sof;
    logic [31:0] dat;
    logic        rdy, iv, hs, vs, bz, ur;
    logic [31:0] din;
  } vec_t;

  function automatic vec_t mk(input logic en, vld, sof, input logic [31:0] dat,
                              input logic rdy, iv, hs, vs, bz, ur, input logic [31:0] din);
    vec_t v;
    v.en = en; v.vld = vld; v.sof = sof; v.dat = dat;
    v.rdy = rdy; v.iv = iv; v.hs = hs; v.vs = vs; v.bz = bz; v.ur = ur; v.din = din;
    return v;
  endfunction

  function automatic logic [31:0] g(input int n);
    return 32'hC0DE_0000 | 32'(n);
  endfunction

  function automatic logic [31:0] h(input int n);
    return 32'hBEEF_0000 | 32'(n);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are observed 1 time unit later.
  task automatic step(input logic r, e, v, so, input logic [31:0] d);
    @(negedge clk);
    rst = r; enable = e; s_valid = v; s_sof = so; s_data = d;
    #1;
  endtask

  task automatic do_reset();
    cfg_hact = 10'd4;
    cfg_vact = 11'd2;
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Continuous upstream stream with sof on group 0; enable drops early and the
  // config changes mid-frame. Counts what reaches the datapath.
  task automatic run_frame(input string name, input logic [9:0] hc, input logic [10:0] vc,
                           input int exp_v, input int exp_hs);
    int n, vcnt, hcnt, vscnt;
    logic done;
    do_reset();
    cfg_hact = hc;
    cfg_vact = vc;
    n = 0; vcnt = 0; hcnt = 0; vscnt = 0; done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i == 5) begin
        cfg_hact = 10'd1;
        cfg_vact = 11'd1;
      end
      step(1'b0, (i < 4), 1'b1, (n == 0), g(n));
      if (dith_in_valid) begin
        chk($sformatf("%s.dat%0d", name, vcnt), dith_in, g(vcnt));
        vcnt++;
      end
      if (dith_hsync) hcnt++;
      if (dith_vsync) vscnt++;
      if (s_ready) n++;
      if (i > 3 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    chk({name, ".done"}, done, 1'b1);
    chk({name, ".valid_cnt"}, vcnt, exp_v);
    chk({name, ".hsync_cnt"}, hcnt, exp_hs);
    chk({name, ".vsync_cnt"}, vscnt, 1);
    chk({name, ".frame_cnt"}, frame_cnt, STATS);
  endtask

  vec_t tbl[39];

  initial begin
    // Frame 1 (r0-r18): clean 4x2. Frame 2 (r19-r38): groups 2-3 of line 0 missing, enable dropped.
    tbl[0]  = mk(1,1,1,g(0), 0,0,0,0,0,0,0);
    tbl[1]  = mk(1,1,1,g(0), 0,0,0,0,1,0,0);
    tbl[2]  = mk(1,1,1,g(0), 0,0,0,0,1,0,0);
    tbl[3]  = mk(1,1,1,g(0), 1,0,0,1,1,0,0);
    tbl[4]  = mk(1,1,0,g(1), 1,1,0,0,1,0,g(0));
    tbl[5]  = mk(1,1,0,g(2), 1,1,0,0,1,0,g(1));
    tbl[6]  = mk(1,1,0,g(3), 1,1,0,0,1,0,g(2));
    tbl[7]  = mk(1,1,0,g(4), 0,1,0,0,1,0,g(3));
    tbl[8]  = mk(1,1,0,g(4), 0,0,0,0,1,0,0);
    tbl[9]  = mk(1,1,0,g(4), 0,0,0,0,1,0,0);
    tbl[10] = mk(1,1,0,g(4), 0,0,0,0,1,0,0);
    tbl[11] = mk(1,1,0,g(4), 1,0,1,0,1,0,0);
    tbl[12] = mk(1,1,0,g(5), 1,1,0,0,1,0,g(4));
    tbl[13] = mk(1,1,0,g(6), 1,1,0,0,1,0,g(5));
    tbl[14] = mk(1,1,0,g(7), 1,1,0,0,1,0,g(6));
    tbl[15] = mk(1,0,0,0,    0,1,0,0,1,0,g(7));
    tbl[16] = mk(1,0,0,0,    0,0,0,0,1,0,0);
    tbl[17] = mk(1,0,0,0,    0,0,0,0,1,0,0);
    tbl[18] = mk(1,0,0,0,    0,0,0,0,1,0,0);
    tbl[19] = mk(1,1,1,h(0), 0,0,1,0,1,0,0);
    tbl[20] = mk(1,1,1,h(0), 0,0,0,0,1,0,0);
    tbl[21] = mk(1,1,1,h(0), 1,0,0,1,1,0,0);
    tbl[22] = mk(1,1,0,h(1), 1,1,0,0,1,0,h(0));
    tbl[23] = mk(1,0,0,0,    1,1,0,0,1,0,h(1));
    tbl[24] = mk(1,0,0,0,    1,1,0,0,1,1,0);
    tbl[25] = mk(1,1,0,h(2), 0,1,0,0,1,1,0);
    tbl[26] = mk(1,1,0,h(2), 0,0,0,0,1,1,0);
    tbl[27] = mk(1,1,0,h(2), 0,0,0,0,1,1,0);
    tbl[28] = mk(1,1,0,h(2), 0,0,0,0,1,1,0);
    tbl[29] = mk(1,1,0,h(2), 1,0,1,0,1,1,0);
    tbl[30] = mk(1,1,0,h(3), 1,1,0,0,1,1,h(2));
    tbl[31] = mk(1,1,0,h(4), 1,1,0,0,1,1,h(3));
    tbl[32] = mk(1,1,0,h(5), 1,1,0,0,1,1,h(4));
    tbl[33] = mk(1,0,0,0,    0,1,0,0,1,1,h(5));
    tbl[34] = mk(0,0,0,0,    0,0,0,0,1,1,0);
    tbl[35] = mk(0,0,0,0,    0,0,0,0,1,1,0);
    tbl[36] = mk(0,0,0,0,    0,0,0,0,1,1,0);
    tbl[37] = mk(0,0,0,0,    0,0,1,0,0,1,0);
    tbl[38] = mk(0,0,0,0,    0,0,0,0,0,1,0);

    do_reset();
    chk("reset.frame_cnt", frame_cnt, 0);
    chk("reset.underrun_cnt", underrun_cnt, 0);
    for (int i = 0; i < 39; i++) begin
      step(1'b0, tbl[i].en, tbl[i].vld, tbl[i].sof, tbl[i].dat);
      chk($sformatf("r%0d.s_ready", i), s_ready, tbl[i].rdy);
      chk($sformatf("r%0d.in_valid", i), dith_in_valid, tbl[i].iv);
      chk($sformatf("r%0d.hsync", i), dith_hsync, tbl[i].hs);
      chk($sformatf("r%0d.vsync", i), dith_vsync, tbl[i].vs);
      chk($sformatf("r%0d.busy", i), busy, tbl[i].bz);
      chk($sformatf("r%0d.underrun", i), underrun, tbl[i].ur);
      chk($sformatf("r%0d.dith_in", i), dith_in, tbl[i].din);
    end
    chk("table.frame_cnt", frame_cnt, 2 * STATS);
    chk("table.underrun_cnt", underrun_cnt, 2 * STATS);

    // Groups ahead of the first sof are accepted and dropped.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h1111_0000);
    chk("disc.idle_ready", s_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h1111_0000 | 32'(i));
      chk($sformatf("disc.ready%0d", i), s_ready, 1'b1);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h5050_5050);
    chk("disc.sof_ready", s_ready, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h5050_5050);
    chk("disc.vsync_state_busy", busy, 1'b1);
    chk("disc.vsync_state_ready", s_ready, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h5050_5050);
    chk("disc.vsync", dith_vsync, 1'b1);
    chk("disc.g0_ready", s_ready, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h5050_5051);
    chk("disc.g0_valid", dith_in_valid, 1'b1);
    chk("disc.g0_data", dith_in, 32'h5050_5050);

    // sof at group 2 of line 0: pad rest of line, blank, then restart with that group.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA_0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA_0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA_0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA_0000);
    chk("rsy.g0_ready", s_ready, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'hAAAA_0001);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h5A5A_0000);
    chk("rsy.sof_reject", s_ready, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h5A5A_0000);
    chk("rsy.g3_ready", s_ready, 1'b0);
    chk("rsy.pad2_valid", dith_in_valid, 1'b1);
    chk("rsy.pad2_data", dith_in, 32'h0);
    chk("rsy.underrun", underrun, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h5A5A_0000);
    chk("rsy.pad3_valid", dith_in_valid, 1'b1);
    chk("rsy.pad3_data", dith_in, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 32'h5A5A_0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h5A5A_0000);
    chk("rsy.hsync", dith_hsync, 1'b1);
    chk("rsy.vsync_state_ready", s_ready, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h5A5A_0000);
    chk("rsy.vsync", dith_vsync, 1'b1);
    chk("rsy.sof_accept", s_ready, 1'b1);
    chk("rsy.underrun_clr", underrun, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h5A5A_0001);
    chk("rsy.g0_data", dith_in, 32'h5A5A_0000);
    chk("rsy.underrun_cnt", underrun_cnt, 2 * STATS);

    // Enable dropped in line 0 finishes both lines; zero config runs as 1x1.
    run_frame("endrop", 10'd4, 11'd2, 8, 2);
    run_frame("zero", 10'd0, 11'd0, 1, 1);

    // Reset in the middle of a line.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h7777_0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h7777_0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h7777_0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h7777_0000);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst.pre_valid", dith_in_valid, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h7777_0001);
    chk("rst.in_valid", dith_in_valid, 1'b0);
    chk("rst.dith_in", dith_in, 32'h0);
    chk("rst.hsync", dith_hsync, 1'b0);
    chk("rst.vsync", dith_vsync, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.ready", s_ready, 1'b0);
    chk("rst.underrun", underrun, 1'b0);
    chk("rst.frame_cnt", frame_cnt, 0);
    chk("rst.underrun_cnt", underrun_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
